// File: rtl/i2s_pkg.sv
// Shared I2S framing constants, types and bit-slot helpers used by the
// transmitter and receiver.
package i2s_pkg;

  localparam int unsigned SMPL_W     = 24;
  localparam int unsigned SLOT_BITS  = 32;
  localparam int unsigned FRAME_BITS = 64;
  localparam int unsigned BIT_CNT_W  = $clog2(FRAME_BITS);
  localparam int unsigned IDX_W      = $clog2(SMPL_W);

  typedef logic [BIT_CNT_W-1:0] bit_cnt_t;

  typedef struct packed {
    logic [SMPL_W-1:0] lft;
    logic [SMPL_W-1:0] rght;
  } smpl_pair_t;

  // Serial data bit for a frame position: MSB-first sample, zero padded slot.
  function automatic logic slot_bit(input smpl_pair_t s, input bit_cnt_t b);
    logic [IDX_W-1:0] idx;
    idx      = '0;
    slot_bit = 1'b0;
    if (b < bit_cnt_t'(SMPL_W)) begin
      idx      = IDX_W'(SMPL_W - 1) - IDX_W'(b);
      slot_bit = s.lft[idx];
    end else if (b >= bit_cnt_t'(SLOT_BITS) && b < bit_cnt_t'(SLOT_BITS + SMPL_W)) begin
      idx      = IDX_W'(SMPL_W - 1) - IDX_W'(b - bit_cnt_t'(SLOT_BITS));
      slot_bit = s.rght[idx];
    end
  endfunction

  // Word select leads each slot's MSB by one bit period.
  function automatic logic ws_bit(input bit_cnt_t b);
    ws_bit = (b >= bit_cnt_t'(SLOT_BITS - 1)) && (b <= bit_cnt_t'(FRAME_BITS - 2));
  endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// I2S bit clock divider and frame bit counter; fe_c flags the edge on which
// the divider wraps and the bit clock falls.
module i2s_clk_gen
  import i2s_pkg::*;
#(
  parameter int unsigned SCLK_DIV = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  output logic     sclk,
  output bit_cnt_t bit_cnt,
  output logic     fe_c,
  output bit_cnt_t bit_cnt_nxt_c
);

  localparam int unsigned DIV_W = $clog2(SCLK_DIV);
  localparam int unsigned HALF  = SCLK_DIV / 2;

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_nxt;

  always_comb begin
    fe_c          = (div_cnt == DIV_W'(SCLK_DIV - 1));
    div_nxt       = fe_c ? '0 : div_cnt + DIV_W'(1);
    bit_cnt_nxt_c = bit_cnt + BIT_CNT_W'(1);
  end

  // sclk is derived from the next count so it stays aligned with div_cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
      bit_cnt <= '1;
    end else begin
      div_cnt <= div_nxt;
      sclk    <= (div_nxt >= DIV_W'(HALF));
      if (fe_c) bit_cnt <= bit_cnt_nxt_c;
    end
  end

endmodule

// File: rtl/i2s_mstr_tx.sv
// I2S master transmitter: single-entry sample buffer with rdy/wrt handshake.
// Define I2S_TX_UNDRN_RPT_EN to repeat the last sample on underrun (else zeros).
module i2s_mstr_tx
  import i2s_pkg::*;
#(
  parameter int unsigned SCLK_DIV = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SMPL_W-1:0] lft_in,
  input  logic [SMPL_W-1:0] rght_in,
  input  logic              wrt,
  output logic              rdy,
  output logic              smpl_req,
  output logic              undrn,
  output logic              I2S_sclk,
  output logic              I2S_ws,
  output logic              I2S_data
);

  bit_cnt_t   bit_cnt;
  bit_cnt_t   bit_cnt_nxt;
  logic       fe;
  logic       frm_start;
  smpl_pair_t hold_q;
  smpl_pair_t tx_q;
  smpl_pair_t tx_nxt;

  i2s_clk_gen #(
    .SCLK_DIV(SCLK_DIV)
  ) u_clk_gen (
    .clk          (clk),
    .rst_n        (rst_n),
    .sclk         (I2S_sclk),
    .bit_cnt      (bit_cnt),
    .fe_c         (fe),
    .bit_cnt_nxt_c(bit_cnt_nxt)
  );

  // Frame start selects the sample for the new frame: buffer or underrun fill.
  always_comb begin
    frm_start = fe && (bit_cnt == bit_cnt_t'(FRAME_BITS - 1));
    tx_nxt    = tx_q;
    if (frm_start) begin
      if (!rdy) begin
        tx_nxt = hold_q;
      end else begin
`ifdef I2S_TX_UNDRN_RPT_EN
        tx_nxt = tx_q;
`else
        tx_nxt = '0;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy      <= 1'b1;
      smpl_req <= 1'b0;
      undrn    <= 1'b0;
      I2S_ws   <= 1'b0;
      I2S_data <= 1'b0;
      hold_q   <= '0;
      tx_q     <= '0;
    end else begin
      smpl_req <= frm_start;
      undrn    <= frm_start && rdy;
      tx_q     <= tx_nxt;
      if (fe) begin
        I2S_ws   <= ws_bit(bit_cnt_nxt);
        I2S_data <= slot_bit(tx_nxt, bit_cnt_nxt);
      end
      // A write on an underrun frame start is kept for the following frame.
      if (wrt && rdy) begin
        hold_q <= '{lft: lft_in, rght: rght_in};
        rdy    <= 1'b0;
      end else if (frm_start) begin
        rdy <= 1'b1;
      end
    end
  end

endmodule

// File: doc/i2s_mstr_tx.md
I2S_MSTR_TX -- requirements
Module: i2s_mstr_tx

Interface
REQ-001 SHALL have parameter: SCLK_DIV, 32, clk cycles per I2S_sclk period; even, >=4.
REQ-002 SHALL have port: clk  input  1  system clock (50MHz).
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: lft_in  input  24  signed left sample to transmit.
REQ-005 SHALL have port: rght_in  input  24  signed right sample to transmit.
REQ-006 SHALL have port: wrt  input  1  load lft_in/rght_in into holding buffer; honoured only when rdy=1.
REQ-007 SHALL have port: rdy  output  1  holding buffer empty; can accept wrt.
REQ-008 SHALL have port: smpl_req  output  1  one-clk pulse at each frame start.
REQ-009 SHALL have port: undrn  output  1  one-clk pulse at a frame start when the buffer is empty.
REQ-010 SHALL have port: I2S_sclk  output  1  bit clock, registered.
REQ-011 SHALL have port: I2S_ws  output  1  word select, 0=left, 1=right, registered.
REQ-012 SHALL have port: I2S_data  output  1  serial data, MSB first, registered.

Function
REQ-013 SHALL run div_cnt 0..SCLK_DIV-1 continuously; I2S_sclk=0 for div_cnt<SCLK_DIV/2, 1 otherwise.
REQ-014 SHALL define a falling-edge event (fe) as the cycle div_cnt wraps to 0; I2S_ws and I2S_data change only on fe.
REQ-015 SHALL keep bit_cnt 0..63, advancing on each fe and wrapping 63->0; the wrap fe is the frame start.
REQ-016 SHALL drive left bits 23..0 during bit_cnt 0..23, 0 during 24..31; right bits 23..0 during 32..55, 0 during 56..63.
REQ-017 SHALL drive I2S_ws=1 for bit_cnt 31..62 and 0 otherwise, giving a one-bit lead before each MSB.
REQ-018 SHALL, at frame start, copy the holding buffer to the shift registers, set rdy=1, and pulse smpl_req.
REQ-019 SHALL, on wrt with rdy=1, capture lft_in/rght_in and drive rdy=0 the next cycle; wrt with rdy=0 is ignored.
REQ-020 SHALL, when wrt coincides with frame start and the buffer is empty, treat the frame as underrun and keep the new data for the next frame.
REQ-021 SHALL, on underrun, pulse undrn and transmit the sample selected per REQ-026.
REQ-022 SHALL transmit data written at cycle t, with the buffer empty, starting with its left MSB at the next frame start.
REQ-023 SHALL produce a frame rate of clk/(64*SCLK_DIV), i.e. 24.414kHz at 50MHz and SCLK_DIV=32.

Reset
REQ-024 SHALL on rst_n low force: div_cnt=0, bit_cnt=63, I2S_sclk=0, I2S_ws=0, I2S_data=0, rdy=1, smpl_req=0, undrn=0, buffer and shift regs=0.
REQ-025 SHALL abandon any frame in progress on reset mid-frame; the first frame start occurs SCLK_DIV clks after rst_n deasserts.

Configuration
REQ-026 SHALL, with I2S_TX_UNDRN_RPT_EN defined, repeat the last transmitted sample on underrun; without it, transmit zeros on underrun.

Structure
REQ-027 SHALL place SMPL_W=24, SLOT_BITS=32, and FRAME_BITS=64 in shared package i2s_pkg, which the I2S receiver also imports.
REQ-028 SHALL implement div_cnt, bit_cnt, I2S_sclk, and fe in sub-module i2s_clk_gen; shift, buffer, and handshake logic stays in the top.

Verification
REQ-029 SHALL check: reset release with SCLK_DIV=32 -> first smpl_req 32 clks later; I2S_sclk period 32 clks, 50% duty.
REQ-030 SHALL check: wrt with lft=24'hA5F00F and rght=24'h800001 -> after frame start, the receiver (I2S_Serf) returns the same values with vld.
REQ-031 SHALL check: ws edge timing -> I2S_ws rises exactly one sclk before the right MSB and falls one sclk before the left MSB.
REQ-032 SHALL check: wrt with rdy=0 -> ignored, buffer unchanged, rdy stays 0 until frame start.
REQ-033 SHALL check: no wrt for one frame -> undrn pulses; data is zeros or repeats 24'hA5F00F per I2S_TX_UNDRN_RPT_EN.
REQ-034 SHALL check: rst_n low at bit_cnt=40 -> all outputs at reset values next cycle; the clean frame restarts per REQ-025.
